// File: rtl/duty_ramp_pkg.sv
// duty_ramp_pkg: shared state encoding and default parameters for the duty-cycle ramp.
package duty_ramp_pkg;

    typedef enum logic [1:0] {IDLE, UP, DOWN} ramp_state_t;

    localparam int DUTY_W_DEF   = 8;
    localparam int PRESCALE_DEF = 256;
    localparam int STEP_DEF     = 1;

endpackage

// File: rtl/duty_ramp_prescaler.sv
// duty_ramp_prescaler: counts enabled clocks 0..PRESCALE-1 and flags the wrap cycle as a tick.
module duty_ramp_prescaler #(
    parameter int PRESCALE = 256
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= o_tick ? '0 : r_cnt + CW'(1);
    end

endmodule

// File: rtl/duty_cycle_ramp.sv
// duty_cycle_ramp: slews the PWM duty cycle toward the programmed target by STEP every PRESCALE clocks.
// Optional ramp-complete pulse output enabled by defining DUTY_RAMP_DONE_EN.
module duty_cycle_ramp
    import duty_ramp_pkg::*;
#(
    parameter int WIDTH    = DUTY_W_DEF,
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int STEP     = STEP_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ena,
    input  logic [WIDTH-1:0] i_target_duty,
    input  logic             i_ramp_en,
    output logic [WIDTH-1:0] o_duty_out,
    output logic             o_busy
`ifdef DUTY_RAMP_DONE_EN
    ,
    output logic             o_ramp_done
`endif
);

    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] r_target_q;
    logic [WIDTH-1:0] r_duty;
    ramp_state_t      r_state;
    logic             r_busy;
    logic             w_gt, w_lt, w_eq;
    logic             w_hold, w_run, w_clr, w_tick;
    logic [WIDTH:0]   w_sum, w_lim;
    logic [WIDTH-1:0] w_up, w_dn, w_next;

    always_comb begin
        w_gt   = r_target_q > r_duty;
        w_lt   = r_target_q < r_duty;
        w_eq   = r_target_q == r_duty;
        // Saturating steps are computed one bit wider so duty never wraps.
        w_sum  = {1'b0, r_duty} + STEP_X;
        w_lim  = {1'b0, r_target_q} + STEP_X;
        w_up   = (w_sum >= {1'b0, r_target_q}) ? r_target_q : w_sum[WIDTH-1:0];
        w_dn   = ({1'b0, r_duty} <= w_lim) ? r_target_q : r_duty - STEP_X[WIDTH-1:0];
        w_next = (r_state == UP) ? w_up : w_dn;
        w_hold = i_ramp_en && ((r_state == UP && w_gt) || (r_state == DOWN && w_lt));
        w_run  = i_ena && w_hold;
        w_clr  = i_ena && !w_hold;
    end

    duty_ramp_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (w_run),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

`ifdef DUTY_RAMP_DONE_EN
    logic r_done;
    assign o_ramp_done = r_done;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_target_q <= '0;
            r_duty     <= '0;
            r_state    <= IDLE;
            r_busy     <= 1'b0;
`ifdef DUTY_RAMP_DONE_EN
            r_done     <= 1'b0;
`endif
        end else if (i_ena) begin
            r_target_q <= i_target_duty;
`ifdef DUTY_RAMP_DONE_EN
            r_done     <= 1'b0;
`endif
            if (!i_ramp_en) begin
                r_duty  <= r_target_q;
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else if (r_state == IDLE) begin
                r_state <= w_gt ? UP : (w_lt ? DOWN : IDLE);
                r_busy  <= !w_eq;
            end else if (!w_hold) begin
                r_state <= w_eq ? IDLE : ((r_state == UP) ? DOWN : UP);
                r_busy  <= !w_eq;
            end else if (w_tick) begin
                r_duty <= w_next;
                if (w_next == r_target_q) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
`ifdef DUTY_RAMP_DONE_EN
                    r_done  <= 1'b1;
`endif
                end
            end
        end
    end

    assign o_duty_out = r_duty;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_duty_cycle_ramp.sv
// tb_duty_cycle_ramp: directed checks of two ramp instances (PRESCALE=4/STEP=1 and PRESCALE=1/STEP=3).
module tb_duty_cycle_ramp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_ena = 1'b1, a_ren = 1'b1;
    logic [7:0] a_tgt = 8'd0;
    logic [7:0] a_duty;
    logic       a_busy;
    logic       b_ena = 1'b1, b_ren = 1'b1;
    logic [7:0] b_tgt = 8'd0;
    logic [7:0] b_duty;
    logic       b_busy;
    int         passed = 0;
    int         failed = 0;
    int         total  = 0;
    int         max_d;
    int         n;
`ifdef DUTY_RAMP_DONE_EN
    logic       a_done, b_done;
`endif

    always #5 clk = ~clk;

    duty_cycle_ramp #(.WIDTH(8), .PRESCALE(4), .STEP(1)) u_a (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_ena         (a_ena),
        .i_target_duty (a_tgt),
        .i_ramp_en     (a_ren),
        .o_duty_out    (a_duty),
        .o_busy        (a_busy)
`ifdef DUTY_RAMP_DONE_EN
        ,
        .o_ramp_done   (a_done)
`endif
    );

    duty_cycle_ramp #(.WIDTH(8), .PRESCALE(1), .STEP(3)) u_b (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_ena         (b_ena),
        .i_target_duty (b_tgt),
        .i_ramp_en     (b_ren),
        .o_duty_out    (b_duty),
        .o_busy        (b_busy)
`ifdef DUTY_RAMP_DONE_EN
        ,
        .o_ramp_done   (b_done)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        step(3);
        chk("rst_a_duty", a_duty, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_b_duty", b_duty, 0);
        rst = 1'b0;
        step(1);
        // Ramp 0 -> 3: steps land at edges 6, 10, 14.
        a_tgt = 8'd3;
        step(1);
        chk("t1_e1_busy", a_busy, 0);
        step(1);
        chk("t1_e2_busy", a_busy, 1);
        chk("t1_e2_duty", a_duty, 0);
        step(3);
        chk("t1_e5_duty", a_duty, 0);
        step(1);
        chk("t1_e6_duty", a_duty, 1);
        step(3);
        chk("t1_e9_duty", a_duty, 1);
        step(1);
        chk("t1_e10_duty", a_duty, 2);
        step(4);
        chk("t1_e14_duty", a_duty, 3);
        chk("t1_e14_busy", a_busy, 0);
`ifdef DUTY_RAMP_DONE_EN
        chk("t1_e14_done", a_done, 1);
`endif
        step(1);
        chk("t1_e15_busy", a_busy, 0);
`ifdef DUTY_RAMP_DONE_EN
        chk("t1_e15_done", a_done, 0);
`endif
        // Bypass: duty follows target two edges after the write.
        a_ren = 1'b0;
        a_tgt = 8'h80;
        step(1);
        chk("t4_e1_duty", a_duty, 3);
        step(1);
        chk("t4_e2_duty", a_duty, 8'h80);
        chk("t4_e2_busy", a_busy, 0);
`ifdef DUTY_RAMP_DONE_EN
        chk("t4_e2_done", a_done, 0);
`endif
        a_ren = 1'b1;
        step(1);
        chk("t4_idle_busy", a_busy, 0);
        a_tgt = 8'h90;
        step(6);
        chk("t4_ramp_duty", a_duty, 8'h81);
        chk("t4_ramp_busy", a_busy, 1);
        a_ren = 1'b0;
        step(1);
        chk("t4_byp_duty", a_duty, 8'h90);
        chk("t4_byp_busy", a_busy, 0);
`ifdef DUTY_RAMP_DONE_EN
        chk("t4_byp_done", a_done, 0);
`endif
        a_ren = 1'b1;
        step(1);
        // Freeze mid-ramp with prescaler at 2, then resume at the same count.
        a_tgt = 8'hA0;
        step(4);
        chk("t5_pre_duty", a_duty, 8'h90);
        a_ena = 1'b0;
        step(20);
        chk("t5_frz_duty", a_duty, 8'h90);
        chk("t5_frz_busy", a_busy, 1);
        a_ena = 1'b1;
        step(1);
        chk("t5_res1_duty", a_duty, 8'h90);
        step(1);
        chk("t5_res2_duty", a_duty, 8'h91);
        step(2);
        rst = 1'b1;
        a_tgt = 8'd0;
        #1;
        chk("t5_arst_duty", a_duty, 0);
        chk("t5_arst_busy", a_busy, 0);
        step(1);
        rst = 1'b0;
        step(1);
        // Reversal: UP toward 200 from 50, retargeted to 10 before the first step.
        a_ren = 1'b0;
        a_tgt = 8'd50;
        step(2);
        chk("t3_start_duty", a_duty, 50);
        a_ren = 1'b1;
        a_tgt = 8'd200;
        step(3);
        a_tgt = 8'd10;
        step(2);
        chk("t3_e5_busy", a_busy, 1);
        step(1);
        chk("t3_e6_duty", a_duty, 50);
        step(2);
        chk("t3_e8_duty", a_duty, 50);
        step(1);
        chk("t3_e9_duty", a_duty, 49);
        max_d = 0;
        n = 0;
        while (a_busy && n < 400) begin
            if (a_duty > max_d) max_d = a_duty;
            step(1);
            n++;
        end
        chk("t3_timeout", (n < 400), 1);
        chk("t3_final_duty", a_duty, 10);
        chk("t3_max_duty", max_d, 49);
        // Saturation with STEP=3, PRESCALE=1.
        b_ren = 1'b0;
        b_tgt = 8'd250;
        step(2);
        chk("t2_start_duty", b_duty, 250);
        b_ren = 1'b1;
        b_tgt = 8'd255;
        step(3);
        chk("t2_e3_duty", b_duty, 253);
        chk("t2_e3_busy", b_busy, 1);
        step(1);
        chk("t2_e4_duty", b_duty, 255);
        chk("t2_e4_busy", b_busy, 0);
        b_ren = 1'b0;
        b_tgt = 8'd2;
        step(2);
        chk("t2_low_duty", b_duty, 2);
        b_ren = 1'b1;
        b_tgt = 8'd0;
        step(2);
        chk("t2_dn_e2_duty", b_duty, 2);
        chk("t2_dn_e2_busy", b_busy, 1);
        step(1);
        chk("t2_dn_e3_duty", b_duty, 0);
        chk("t2_dn_e3_busy", b_busy, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
